dcpu16_ram: RTL

Dual-port memory responder for the DCPU16 core. It serves the simplified-Wishbone G-BUS, the operand and next-word read bus, and the F-BUS, the fetch and operand write-back bus. Both ports share one single-port word RAM through a round-robin arbiter. Each port's ack is held until the core's pipe-advance `ena` consumes the transaction. The block sits between the CPU and the system memory map and replaces the testbench memory models.

---
 rtl/dcpu16_pkg.sv | 18 +
 rtl/dcpu16_spram.sv | 28 ++
 rtl/dcpu16_ram.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dcpu16_pkg.sv
// Shared definitions for the DCPU16 memory responder: port FSM state
// encoding and the port-select constants used to index per-port signals.
package dcpu16_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_ACC  = 3'd2,
    ST_WT   = 3'd3,
    ST_DONE = 3'd4
  } port_state_e;

  localparam logic PORT_G = 1'b0;
  localparam logic PORT_F = 1'b1;

  localparam int DW = 16;

endpackage

// File: rtl/dcpu16_spram.sv
// Single-port synchronous word RAM, one-cycle read latency, write-first.
// Contents are never reset.
module dcpu16_spram #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] rd
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[adr] <= wd;
        rd       <= wd;
      end else begin
        rd <= mem[adr];
      end
    end
  end

endmodule

// File: rtl/dcpu16_ram.sv
// DCPU16 dual-port memory responder: G-BUS (read-only) and F-BUS share one RAM
// via a round-robin arbiter. Define DCPU16_RAM_WSTATE_EN to add WAIT wait states.
module dcpu16_ram
  import dcpu16_pkg::*;
#(
  parameter int AW   = 16,
  parameter int WAIT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic [15:0]   g_adr,
  input  logic          g_stb,
  input  logic          g_wre,
  output logic [15:0]   g_dti,
  output logic          g_ack,
  input  logic [15:0]   f_adr,
  input  logic          f_stb,
  input  logic          f_wre,
  input  logic [15:0]   f_dto,
  output logic [15:0]   f_dti,
  output logic          f_ack
);

`ifdef DCPU16_RAM_WSTATE_EN
  localparam int CW = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
`endif

  logic [1:0]    stb;
  logic [1:0]    req;
  logic [1:0]    gnt;
  logic          last;
  logic          last_nx;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_adr;
  logic [DW-1:0] ram_rd;
  logic          unused_ok;

  assign stb[PORT_G] = g_stb;
  assign stb[PORT_F] = f_stb;

  // `last` remembers only the winner of the most recent collision, so the
  // next collision goes to the other port.
  always_comb begin
    gnt     = req;
    last_nx = last;
    if (req == 2'b11) begin
      if (last == PORT_G) begin
        gnt     = 2'b10;
        last_nx = PORT_F;
      end else begin
        gnt     = 2'b01;
        last_nx = PORT_G;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) last <= PORT_G;
    else     last <= last_nx;
  end

  assign ram_en  = |gnt;
  assign ram_we  = gnt[PORT_F] & f_wre;
  assign ram_adr = gnt[PORT_F] ? f_adr[AW-1:0] : g_adr[AW-1:0];

  dcpu16_spram #(.AW(AW), .DW(DW)) u_ram (
    .clk (clk),
    .en  (ram_en),
    .we  (ram_we),
    .adr (ram_adr),
    .wd  (f_dto),
    .rd  (ram_rd)
  );

  for (genvar p = 0; p < 2; p++) begin : g_port
    port_state_e   st;
    port_state_e   st_nx;
    logic          ack_q;
    logic [DW-1:0] dti_q;
`ifdef DCPU16_RAM_WSTATE_EN
    logic [CW-1:0] cnt;
`endif

    assign req[p] = (st == ST_REQ) && stb[p] && !rst;

    always_comb begin
      st_nx = st;
      case (st)
        ST_IDLE: if (stb[p]) st_nx = ST_REQ;
        ST_REQ: begin
          if (gnt[p])       st_nx = ST_ACC;
          else if (!stb[p]) st_nx = ST_IDLE;
        end
`ifdef DCPU16_RAM_WSTATE_EN
        ST_ACC: begin
          if (WAIT > 0) st_nx = ST_WT;
          else          st_nx = ST_DONE;
        end
        ST_WT: if (cnt == CW'(WAIT - 1)) st_nx = ST_DONE;
`else
        ST_ACC: st_nx = ST_DONE;
`endif
        ST_DONE: begin
          if (ena) begin
            if (stb[p]) st_nx = ST_REQ;
            else        st_nx = ST_IDLE;
          end
        end
        default: st_nx = ST_IDLE;
      endcase
    end

    // Ack mirrors residence in DONE, which gives a registered, held ack.
    always_ff @(posedge clk) begin
      if (rst) begin
        st    <= ST_IDLE;
        ack_q <= 1'b0;
        dti_q <= '0;
      end else begin
        st    <= st_nx;
        ack_q <= (st_nx == ST_DONE);
        if (st == ST_ACC) dti_q <= ram_rd;
      end
    end

`ifdef DCPU16_RAM_WSTATE_EN
    always_ff @(posedge clk) begin
      if (rst)               cnt <= '0;
      else if (st == ST_ACC) cnt <= '0;
      else if (st == ST_WT)  cnt <= cnt + 1'b1;
    end
`endif
  end

  assign g_ack = g_port[0].ack_q;
  assign g_dti = g_port[0].dti_q;
  assign f_ack = g_port[1].ack_q;
  assign f_dti = g_port[1].dti_q;

  // G writes are meaningless and address bits above AW alias.
  assign unused_ok = ^{g_wre, g_adr, f_adr, (WAIT != 0)};

endmodule
